dsc_s2b_decoder: RTL and testbench
==================================

Name: dsc_s2b_decoder

Overview:
- Stochastic-to-binary decoder for the deterministic stochastic computing (DSC) datapath.
- Counts the ones in a deterministic unary/stochastic bitstream over a fixed window of 2^WIN_BITS valid bits.
- Presents the count as a binary result with a valid/ready handshake.
- Sits at the output end of the dsc_mul product stream. It also serves as a standalone checker that decodes encoder streams back to binary.

Parameters:
- WIN_BITS, 24, log2 of window length in valid bits (NUM_INPUTS*NUM_BITS = 4*6 for the 4-input 6-bit multiplier).
- SAT_EN, 1, when 1 a full-ones window saturates z to all ones; when 0 z wraps to 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a new window; sampled in IDLE, or in HOLD when the result handshake completes.
- abort  input  1  synchronous cancel of the current window; returns to IDLE.
- en  input  1  qualifies sn_in; bits with en=0 are ignored and do not advance the window.
- sn_in  input  1  stochastic bitstream bit.
- z  output  WIN_BITS  decoded ones count.
- z_valid  output  1  result available.
- z_ready  input  1  consumer accepts result.
- sat  output  1  the window was all ones (count = 2^WIN_BITS); valid with z_valid.
- busy  output  1  high in ACCUM.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - z=0, z_valid=0, sat=0, busy=0; internal counters cleared.
  - Reset during ACCUM or HOLD discards all progress; no z_valid follows reset release.
- States:
  - IDLE:
    - start=1: clear bit_cnt (WIN_BITS wide) and ones_cnt (WIN_BITS+1 wide), go to ACCUM.
    - The start-cycle sn_in is not counted.
  - ACCUM (busy=1):
    - Each cycle with en=1: bit_cnt+=1, and ones_cnt+=sn_in.
    - Last bit is the en=1 cycle with bit_cnt = all ones.
    - On the last bit, z is registered from ones_cnt+sn_in and the state goes to HOLD. z_valid rises on the next clock edge (latency 1 cycle after the last valid bit).
    - start in ACCUM is ignored.
  - HOLD:
    - z_valid=1; z and sat are stable until the handshake completes.
    - z_valid & z_ready: if start=1 in the same cycle, go to ACCUM with counters cleared (back-to-back, no idle cycle). Otherwise go to IDLE.
    - z_valid drops the cycle after acceptance. z holds its last value; sat clears.
    - start without z_ready is ignored.
- Width rule:
  - Full count = 2^WIN_BITS (one more than z can hold). In that case sat=1.
  - SAT_EN=1: z = all ones. SAT_EN=0: z = 0.
  - Any count below the full count: z = count exactly, sat=0.
- abort:
  - Takes priority over everything except rst.
  - In ACCUM or HOLD: go to IDLE next cycle, z_valid=0, counters cleared, z unchanged.
  - abort and start together in IDLE: stay in IDLE.
- en=0 for any number of cycles in ACCUM stalls the window indefinitely; no timeout.
- Window wrap: bit_cnt wraps only on the last bit. ones_cnt never wraps.

Decomposition:
- Shared package dsc_pkg:
  - State enum (IDLE, ACCUM, HOLD).
  - DSC_NUM_INPUTS=4, DSC_NUM_BITS=6, DSC_WIN_BITS derived from them.
  - Shared with dsc_mul and the encoders.
- Sub-module dsc_ctr:
  - Parameterised up-counter with asynchronous active-low reset, synchronous clr, en, and a terminal-count flag.
  - Instantiated twice (bit_cnt, ones_cnt).

Test Plan (WIN_BITS=4 override, 16-bit window, z_ready=1 unless stated):
- start, then 16 cycles en=1 sn_in=1 -> z_valid 1 cycle after the 16th bit; z=15, sat=1 (SAT_EN=1). Same stimulus with SAT_EN=0 -> z=0, sat=1.
- start, then 16 bits alternating 1,0 with en=1 -> z=8, sat=0; busy high for exactly 16 cycles.
- start, then 16 valid bits containing 5 ones, with en=0 gaps of 3 cycles between bits carrying sn_in=1 -> z=5; bits with en=0 not counted.
- Complete a window with z_ready=0 for 10 cycles and start pulsed during them -> z and z_valid stable, start ignored. Then z_ready=1 with start=1 -> next window begins without an idle cycle; second result correct (all zeros -> z=0).
- abort after 7 valid bits -> IDLE next cycle, no z_valid. New window of 3 ones -> z=3; no residue from the aborted window.
- Assert rst low mid-ACCUM (asynchronously, between clock edges) -> z, z_valid, busy go to 0 immediately. After release, no z_valid until a new start plus 16 valid bits.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared DSC datapath definitions: FSM state encoding and window geometry
// used by dsc_mul, the encoders and the stochastic-to-binary decoder.
package dsc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } dsc_state_t;

  localparam int DSC_NUM_INPUTS = 4;
  localparam int DSC_NUM_BITS   = 6;
  localparam int DSC_WIN_BITS   = DSC_NUM_INPUTS * DSC_NUM_BITS;
endpackage

// File: rtl/dsc_ctr.sv
// Up-counter with synchronous clear (priority over en) and a flag that is
// high while the count equals MAX.
module dsc_ctr #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == MAX);
endmodule

// File: rtl/dsc_s2b_decoder.sv
// Counts ones over a 2^WIN_BITS-bit window of qualified stochastic bits and
// presents the count on z with a valid/ready handshake (1 cycle after last bit).
module dsc_s2b_decoder
  import dsc_pkg::*;
#(
  parameter int WIN_BITS = DSC_WIN_BITS,
  parameter int SAT_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                en,
  input  logic                sn_in,
  output logic [WIN_BITS-1:0] z,
  output logic                z_valid,
  input  logic                z_ready,
  output logic                sat,
  output logic                busy
);
  dsc_state_t state;

  logic [WIN_BITS-1:0] bit_cnt;
  logic [WIN_BITS:0]   ones_cnt;
  logic                bit_tc;
  logic                ones_tc;
  logic                start_win;
  logic                last_bit;
  logic                full;
  logic                ctr_clr;
  logic                bit_inc;
  logic                ones_inc;
  logic [WIN_BITS-1:0] z_nxt;

  assign start_win = !abort && start &&
                     ((state == IDLE) || (state == HOLD && z_ready));
  assign bit_inc   = (state == ACCUM) && en;
  assign ones_inc  = bit_inc && sn_in;
  assign last_bit  = bit_inc && bit_tc;
  assign ctr_clr   = abort || start_win || last_bit;

  // ones_cnt sitting at 2^W-1 plus a final one is the only way to reach the full count.
  assign full  = ones_tc && sn_in;
  assign z_nxt = WIN_BITS'(ones_cnt + (WIN_BITS + 1)'(sn_in));

  dsc_ctr #(
    .W   (WIN_BITS),
    .MAX ({WIN_BITS{1'b1}})
  ) u_bit_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (bit_inc),
    .cnt (bit_cnt),
    .tc  (bit_tc)
  );

  dsc_ctr #(
    .W   (WIN_BITS + 1),
    .MAX ({1'b0, {WIN_BITS{1'b1}}})
  ) u_ones_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ones_inc),
    .cnt (ones_cnt),
    .tc  (ones_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      z       <= '0;
      z_valid <= 1'b0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      z_valid <= 1'b0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (last_bit) begin
            state   <= HOLD;
            busy    <= 1'b0;
            z_valid <= 1'b1;
            sat     <= full;
            if (full) z <= (SAT_EN != 0) ? '1 : '0;
            else      z <= z_nxt;
          end
        end
        HOLD: begin
          if (z_ready) begin
            z_valid <= 1'b0;
            sat     <= 1'b0;
            if (start) begin
              state <= ACCUM;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          z_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_s2b_decoder.sv
// Directed bench for dsc_s2b_decoder with a 16-bit window; two instances
// differ only in SAT_EN and share all stimulus.
module tb_dsc_s2b_decoder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         en = 1'b0;
  logic         sn_in = 1'b0;
  logic         z_ready = 1'b1;
  logic [W-1:0] z, z0;
  logic         z_valid, z_valid0, sat, sat0, busy, busy0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] bits;
    int          gap;
    int          exp_z;
    int          exp_sat;
    int          exp_z0;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  dsc_s2b_decoder #(.WIN_BITS(W), .SAT_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .sn_in(sn_in),
    .z(z), .z_valid(z_valid), .z_ready(z_ready), .sat(sat), .busy(busy)
  );

  dsc_s2b_decoder #(.WIN_BITS(W), .SAT_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .sn_in(sn_in),
    .z(z0), .z_valid(z_valid0), .z_ready(z_ready), .sat(sat0), .busy(busy0)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int gap, output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        en = 1'b0; sn_in = 1'b1;
        step();
        if (busy) busy_n++;
      end
      en = 1'b1; sn_in = bits[i];
      step();
      if (busy) busy_n++;
    end
    en = 1'b0; sn_in = 1'b0;
  endtask

  task automatic send_window(input logic [15:0] bits, input int gap, output int busy_n);
    int b;
    start = 1'b1;
    step();
    start = 1'b0;
    b = busy ? 1 : 0;
    send_bits(bits, gap, busy_n);
    busy_n += b;
  endtask

  initial begin
    int bn;
    int seen;

    vecs[0] = '{16'hFFFF, 0, 15, 1, 0};
    vecs[1] = '{16'hAAAA, 0, 8,  0, 8};
    vecs[2] = '{16'h8423, 3, 5,  0, 5};
    vecs[3] = '{16'h0000, 0, 0,  0, 0};
    vecs[4] = '{16'h7FFF, 0, 15, 0, 15};

    #20;
    check("reset_z",       int'(z),       0);
    check("reset_z_valid", int'(z_valid), 0);
    check("reset_sat",     int'(sat),     0);
    check("reset_busy",    int'(busy),    0);
    #2 rst = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      send_window(vecs[v].bits, vecs[v].gap, bn);
      check($sformatf("v%0d_z_valid", v), int'(z_valid), 1);
      check($sformatf("v%0d_z", v),       int'(z),       vecs[v].exp_z);
      check($sformatf("v%0d_sat", v),     int'(sat),     vecs[v].exp_sat);
      check($sformatf("v%0d_z_nosat", v), int'(z0),      vecs[v].exp_z0);
      check($sformatf("v%0d_sat_nosat", v), int'(sat0),  vecs[v].exp_sat);
      check($sformatf("v%0d_busy_cycles", v), bn, 16 * (1 + vecs[v].gap));
      step();
      check($sformatf("v%0d_valid_drop", v), int'({z_valid, sat}), 0);
    end

    // result held while the consumer stalls; start is ignored meanwhile
    z_ready = 1'b0;
    send_window(16'h00FF, 0, bn);
    check("hold_first", int'({z_valid, busy, z}), int'({1'b1, 1'b0, 4'd8}));
    for (int k = 0; k < 10; k++) begin
      start = (k % 3 == 0);
      step();
      check($sformatf("hold_stable_%0d", k), int'({z_valid, busy, z}), int'({1'b1, 1'b0, 4'd8}));
    end
    z_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", int'({busy, z_valid}), int'({1'b1, 1'b0}));
    send_bits(16'h0000, 0, bn);
    check("b2b_result", int'({z_valid, sat, z}), int'({1'b1, 1'b0, 4'd0}));
    step();

    // abort mid-window, then abort+start together in IDLE
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; sn_in = 1'b1;
      step();
    end
    en = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", int'({busy, z_valid}), 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (z_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", int'(busy), 0);
    send_window(16'h0007, 0, bn);
    check("after_abort_z", int'({z_valid, sat, z}), int'({1'b1, 1'b0, 4'd3}));
    step();

    // abort in HOLD keeps z but drops z_valid
    z_ready = 1'b0;
    send_window(16'h000F, 0, bn);
    check("hold_pre_abort", int'({z_valid, z}), int'({1'b1, 4'd4}));
    abort = 1'b1;
    step();
    abort = 1'b0; z_ready = 1'b1;
    check("hold_abort", int'({z_valid, busy, z}), int'({1'b0, 1'b0, 4'd4}));

    // asynchronous reset mid-window
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; sn_in = 1'b1;
      step();
    end
    #3 rst = 1'b0;
    #1;
    check("arst_z",     int'(z),       0);
    check("arst_valid", int'(z_valid), 0);
    check("arst_busy",  int'({busy, busy0}), 0);
    #12 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (z_valid || busy) seen++;
    end
    en = 1'b0; sn_in = 1'b0;
    check("post_rst_quiet", seen, 0);
    send_window(16'h0003, 0, bn);
    check("post_rst_z", int'({z_valid, sat, z}), int'({1'b1, 1'b0, 4'd2}));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
